// File: rtl/tone_pkg.sv
// Shared types and default constants for the tone arbiter slice.
// Optional feature macro used by tone_arbiter: TONE_PREEMPT_EN.
package tone_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam int N_REQ_DEF    = 4;
   localparam int PERIOD_W_DEF = 12;
   localparam int DUR_W_DEF    = 10;
   localparam int TICK_DIV_DEF = 1000;
   localparam int GAP_MS_DEF   = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tone_arbiter_if.sv
// Request bundle between sound-effect requesters and the tone arbiter.
// Slices of the packed fields are indexed by requester id.
interface tone_arbiter_if
   import tone_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int PERIOD_W = PERIOD_W_DEF,
   parameter int DUR_W    = DUR_W_DEF
) ();

   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ-1:0]          req_ready;
   logic [N_REQ*PERIOD_W-1:0] req_half_period;
   logic [N_REQ*DUR_W-1:0]    req_duration;

   modport master (
      output req_valid,
      output req_half_period,
      output req_duration,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_half_period,
      input  req_duration,
      output req_ready
   );

endinterface

// File: rtl/tone_gen.sv
// Programmable square-wave generator. Counts 0..2*hp-1 while enabled and
// registers dac high for the first hp counts; dropping en clears the counter.
module tone_gen
   import tone_pkg::*;
#(
   parameter int PERIOD_W = PERIOD_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [PERIOD_W-1:0] half_period,
   output logic                dac_out
);

   logic [PERIOD_W:0] cnt_q, cnt_d;
   logic [PERIOD_W:0] full_period;
   logic              dac_q, dac_d;

   assign full_period = {half_period, 1'b0};

   // Next counter value and next output bit.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      cnt_d = '0;
      dac_d = 1'b0;
      if (en) begin
         dac_d = (cnt_q < {1'b0, half_period});
         cnt_d = (cnt_q >= full_period - 1'b1) ? '0 : cnt_q + 1'b1;
      end
   end

   // Counter and output register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         cnt_q <= '0;
         dac_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         dac_q <= dac_d;
      end
   end

   // Gating with en silences the output the moment the tone is stopped.
   assign dac_out = dac_q & en;

endmodule

// File: rtl/tone_arbiter.sv
// Round-robin arbiter sharing one square-wave generator between requesters.
// Each accepted tone plays for its duration in ms, followed by a silent gap.
// Define TONE_PREEMPT_EN to let requester 0 interrupt any other tone.
module tone_arbiter
   import tone_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int PERIOD_W = PERIOD_W_DEF,
   parameter int DUR_W    = DUR_W_DEF,
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int GAP_MS   = GAP_MS_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   tone_arbiter_if.slave            req,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] active_id,
   output logic                     dac_out
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int PRE_W = $clog2(TICK_DIV + 1);
   localparam int MS_W  = max_int(DUR_W, $clog2(GAP_MS + 1) + 1);
   localparam logic [MS_W-1:0]  GAP_LOAD = MS_W'(GAP_MS);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     rr_q, rr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [PERIOD_W-1:0] hp_q, hp_d;
   logic [MS_W-1:0]     ms_q, ms_d;
   logic [PRE_W-1:0]    pre_q, pre_d;

   logic [ID_W-1:0]     grant;
   logic                grant_vld;
   logic [N_REQ-1:0]    ready;
   logic                take;
   logic                preempt;
   logic [ID_W-1:0]     sel_id;
   logic [PERIOD_W-1:0] sel_hp;
   logic [DUR_W-1:0]    sel_dur;
   logic                tick;
   logic                tone_en;

   assign tick = (pre_q == PRE_LAST);

   // Round-robin pick: first valid requester at or after rr_q, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_vld = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_q) + k) % N_REQ;
         if (!grant_vld && req.req_valid[idx]) begin
            grant_vld = 1'b1;
            grant     = ID_W'(idx);
         end
      end
   end

   // FSM next state, handshake, capture and ms/duration counting.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      hp_d    = hp_q;
      ms_d    = ms_q;
      pre_d   = '0;
      ready   = '0;
      take    = 1'b0;
      preempt = 1'b0;
      sel_id  = grant;
      sel_hp  = '0;
      sel_dur = '0;

      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               ready[grant] = 1'b1;
               take         = 1'b1;
            end
         end
         PLAY: begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
               if (ms_q == MS_W'(1)) begin
                  if (GAP_MS > 0) begin
                     state_d = GAP;
                     ms_d    = GAP_LOAD;
                  end else begin
                     state_d = IDLE;
                     ms_d    = '0;
                  end
               end else begin
                  ms_d = ms_q - 1'b1;
               end
            end
         end
         GAP: begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
               if (ms_q == MS_W'(1)) begin
                  state_d = IDLE;
                  ms_d    = '0;
               end else begin
                  ms_d = ms_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef TONE_PREEMPT_EN
      // Requester 0 cuts in on any tone or gap owned by another requester.
      if (state_q != IDLE && id_q != '0 && req.req_valid[0]) begin
         ready    = '0;
         ready[0] = 1'b1;
         preempt  = 1'b1;
         take     = 1'b1;
         sel_id   = '0;
      end
`endif

      if (take) begin
         sel_hp  = req.req_half_period[int'(sel_id)*PERIOD_W +: PERIOD_W];
         sel_dur = req.req_duration[int'(sel_id)*DUR_W +: DUR_W];
         id_d    = sel_id;
         hp_d    = sel_hp;
         pre_d   = '0;
         // A preempt leaves the rotation where it was.
         if (!preempt) begin
            rr_d = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
         end
         if (sel_dur == '0) begin
            if (GAP_MS > 0) begin
               state_d = GAP;
               ms_d    = GAP_LOAD;
            end else begin
               state_d = IDLE;
               ms_d    = '0;
            end
         end else begin
            state_d = PLAY;
            ms_d    = MS_W'(sel_dur);
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         id_q    <= '0;
         hp_q    <= '0;
         ms_q    <= '0;
         pre_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         hp_q    <= hp_d;
         ms_q    <= ms_d;
         pre_q   <= pre_d;
      end
   end

   // The generator is held off for the preempt cycle so the new tone starts from count 0.
   assign tone_en = (state_q == PLAY) && (hp_q != '0) && !preempt;

   tone_gen #(
      .PERIOD_W (PERIOD_W)
   ) u_tone_gen (
      .clk         (clk),
      .rst         (rst),
      .en          (tone_en),
      .half_period (hp_q),
      .dac_out     (dac_out)
   );

   // Ready is forced low while reset is held, since IDLE arbitration is combinational.
   assign req.req_ready = ready & {N_REQ{rst}};
   assign busy          = (state_q != IDLE);
   assign active_id     = id_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter with TICK_DIV = 10 and GAP_MS = 2.
module tb_tone_arbiter;

   localparam int TICK = 10;
   localparam int GAPN = 2;

   logic       clk;
   logic       rst;
   logic       busy;
   logic [1:0] active_id;
   logic       dac_out;

   int checks = 0;
   int errors = 0;

   tone_arbiter_if #(.N_REQ(4), .PERIOD_W(12), .DUR_W(10)) bus ();

   tone_arbiter #(
      .N_REQ    (4),
      .PERIOD_W (12),
      .DUR_W    (10),
      .TICK_DIV (TICK),
      .GAP_MS   (GAPN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (bus),
      .busy      (busy),
      .active_id (active_id),
      .dac_out   (dac_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_slices(input int hp, input int dur);
      for (int i = 0; i < 4; i++) begin
         bus.req_half_period[i*12 +: 12] = 12'(hp);
         bus.req_duration[i*10 +: 10]    = 10'(dur);
      end
   endtask

   // Present a request in an IDLE cycle, check the grant, then apply v_after past the edge.
   task automatic transfer(input logic [3:0] v, input logic [3:0] exp_rdy, input int hp,
                           input int dur, input logic [3:0] v_after, input bit wait_edge,
                           input string tag);
      if (wait_edge) @(negedge clk);
      set_slices(hp, dur);
      bus.req_valid = v;
      #1;
      check({tag, "_ready"}, bus.req_ready, exp_rdy);
      check({tag, "_idle"}, busy, 1'b0);
      @(posedge clk);
      #1;
      bus.req_valid = v_after;
   endtask

   // Follow a tone cycle by cycle from the first cycle after transfer.
   task automatic window(input int hp, input int dur, input int exp_id,
                         input logic [3:0] exp_next, input int stop_k, input string tag);
      int   play_len;
      int   busy_len;
      int   n;
      logic exp_dac;
      play_len = dur * TICK;
      busy_len = play_len + GAPN * TICK;
      n        = busy_len + 1;
      if (stop_k > 0 && stop_k < n) n = stop_k;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         exp_dac = (hp != 0 && k >= 2 && k <= play_len) ? (((k - 2) % (2 * hp)) < hp) : 1'b0;
         if (k == 1) check({tag, "_id"}, active_id, exp_id);
         if (k <= busy_len) begin
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_rdy0"}, bus.req_ready, 4'b0000);
            check({tag, "_dac"}, dac_out, exp_dac);
         end else begin
            check({tag, "_end_busy"}, busy, 1'b0);
            check({tag, "_end_dac"}, dac_out, 1'b0);
            check({tag, "_next_rdy"}, bus.req_ready, exp_next);
         end
      end
   endtask

   initial begin
      rst             = 1'b0;
      bus.req_valid   = 4'b1111;
      set_slices(5, 1);

      // Reset state, with all requesters asking.
      #2;
      check("rst_ready", bus.req_ready, 4'b0000);
      check("rst_busy", busy, 1'b0);
      check("rst_dac", dac_out, 1'b0);
      check("rst_id", active_id, 2'd0);
      repeat (2) @(negedge clk);
      rst           = 1'b1;
      bus.req_valid = 4'b0000;
      #1;
      check("post_rst_ready", bus.req_ready, 4'b0000);
      check("post_rst_busy", busy, 1'b0);

      // Round robin: 1 and 2 together from rr_ptr 0; 2 holds and follows.
      transfer(4'b0110, 4'b0010, 2, 1, 4'b0100, 1'b1, "rr_a1");
      window(2, 1, 1, 4'b0100, 0, "rr_a1_t");
      transfer(4'b0100, 4'b0100, 2, 1, 4'b0000, 1'b0, "rr_a2");
      window(2, 1, 2, 4'b0000, 0, "rr_a2_t");
      // rr_ptr is now 3, so 1 beats 2; afterwards rr_ptr 2 lets 2 win.
      transfer(4'b0110, 4'b0010, 2, 1, 4'b0110, 1'b1, "rr_b1");
      window(2, 1, 1, 4'b0100, 0, "rr_b1_t");
      transfer(4'b0110, 4'b0100, 2, 1, 4'b0000, 1'b0, "rr_b2");
      window(2, 1, 2, 4'b0000, 0, "rr_b2_t");

      // Single request hp 3, D 4: 40 play cycles plus 20 gap cycles.
      transfer(4'b0001, 4'b0001, 3, 4, 4'b0000, 1'b1, "single");
      window(3, 4, 0, 4'b0000, 0, "single_t");

      // Zero duration from requester 3: straight into the gap.
      transfer(4'b1000, 4'b1000, 7, 0, 4'b0000, 1'b1, "dur0");
      window(7, 0, 3, 4'b0000, 0, "dur0_t");

      // Rest tone: hp 0 keeps dac low for the whole 50 busy cycles.
      transfer(4'b0010, 4'b0010, 0, 3, 4'b0000, 1'b1, "rest");
      window(0, 3, 1, 4'b0000, 0, "rest_t");

`ifdef TONE_PREEMPT_EN
      // Requester 0 cuts in at cycle 15 of requester 2's tone.
      transfer(4'b0100, 4'b0100, 4, 5, 4'b0000, 1'b1, "pre_own");
      window(4, 5, 2, 4'b0000, 15, "pre_own_t");
      set_slices(1, 2);
      bus.req_valid = 4'b0001;
      #1;
      check("pre_ready", bus.req_ready, 4'b0001);
      @(posedge clk);
      #1;
      bus.req_valid = 4'b0011;
      // rr_ptr stays 3 across the preempt, so 0 wins over 1 afterwards.
      window(1, 2, 0, 4'b0001, 0, "pre_t");
      bus.req_valid = 4'b0000;
`endif

      // Reset in the middle of requester 2's tone.
      transfer(4'b0100, 4'b0100, 1, 5, 4'b0000, 1'b1, "mid");
      window(1, 5, 2, 4'b0000, 2, "mid_t");
      bus.req_valid = 4'b1000;
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_dac", dac_out, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_ready", bus.req_ready, 4'b0000);
      check("mid_rst_id", active_id, 2'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rel_busy", busy, 1'b0);
      bus.req_valid = 4'b1010;
      #1;
      check("mid_rel_rr", bus.req_ready, 4'b0010);
      bus.req_valid = 4'b0000;
      repeat (3) @(negedge clk);
      check("mid_final_busy", busy, 1'b0);
      check("mid_final_dac", dac_out, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tone_arbiter.md
# tone_arbiter

Shares the single square-wave audio generator among several sound-effect requesters (step judgments, menu clicks, metronome). It accepts tone requests via valid/ready, grants one at a time round-robin, and plays each tone for a requested number of milliseconds. Between tones it inserts a fixed silent gap. The programmable square-wave generator is instantiated inside, and the block drives the 1-bit `dac_out` consumed by the audio output stage.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `PERIOD_W`, 12: half-period width, in clk cycles.
- `DUR_W`, 10: duration width, in ms.
- `TICK_DIV`, 1000: clk cycles per ms tick (1 MHz clk).
- `GAP_MS`, 2: silent gap after each tone, in ms. 0 = no gap.

Ports:
- `clk`  in  1: system clock, 1 MHz.
- `rst`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  N_REQ: per-requester request valid.
- `req_ready`  out  N_REQ: per-requester accept; one-hot or zero.
- `req_half_period`  in  N_REQ*PERIOD_W: packed; slice i = half-period of requester i. 0 = rest (silence).
- `req_duration`  in  N_REQ*DUR_W: packed; slice i = duration in ms.
- `busy`  out  1: high in PLAY or GAP.
- `active_id`  out  $clog2(N_REQ): index of the last granted requester.
- `dac_out`  out  1: square-wave audio bit.

## Operation
- States:
  - IDLE: no tone; arbitrating.
  - PLAY: tone running for the accepted duration.
  - GAP: silence between tones.
- Arbitration, IDLE only:
  - Grant = first asserted `req_valid` at or after `rr_ptr`, wrapping.
  - `req_ready[grant]` is combinational and high in IDLE only.
  - Transfer occurs when valid && ready.
  - On transfer: capture half-period, duration and id; set `rr_ptr` = id+1 mod N_REQ.
- Transfer with duration 0: request consumed, no PLAY; next state GAP, or IDLE if GAP_MS = 0.
- Transfer with duration D > 0: next state PLAY.
  - Ms prescaler cleared on PLAY entry.
  - Duration counter decrements on each tick; leaving PLAY when it reaches 0 → GAP, or IDLE if GAP_MS = 0.
- GAP: GAP_MS ticks, then IDLE.
- Tone generator:
  - Runs when in PLAY and half-period ≠ 0.
  - Counter counts 0..2·hp−1 and wraps.
  - `dac_out` = 1 while counter < hp, else 0.
  - Counter cleared whenever a tone starts or is disabled.
- Requester inputs may change after transfer; captured values are used.
- Reset:
  - Async-assert to IDLE.
  - `req_ready` = 0, `busy` = 0, `active_id` = 0, `dac_out` = 0, `rr_ptr` = 0, all counters 0.
  - Asserting reset mid-PLAY silences output immediately; the tone is not resumed.

## Timing
- Transfer at cycle T: `busy` = 1 from T+1; `dac_out` first high at T+2.
- PLAY lasts exactly D·TICK_DIV cycles.
- GAP lasts exactly GAP_MS·TICK_DIV cycles.
- Earliest next transfer is the first IDLE cycle after GAP; `req_ready` is 0 throughout PLAY and GAP.
- Output period = 2·hp cycles. The half-period is 1 cycle minimum when hp = 1.
- Multiple simultaneous valids: exactly one transfer per IDLE cycle. Losers hold valid and are served in rotation order.

## Configuration
- `TONE_PREEMPT_EN` defined:
  - Requester 0 is urgent.
  - While in PLAY or GAP serving id ≠ 0, `req_valid[0]` raises `req_ready[0]` the same cycle.
  - On transfer, PLAY restarts with requester 0's tone: tone counter and prescaler cleared, no gap.
  - `rr_ptr` is unchanged by a preempt.
  - A playing id-0 tone is never preempted.
- `TONE_PREEMPT_EN` undefined: requester 0 arbitrates like all others; no preemption logic is present.

## Structure
- Package `tone_pkg`: state enum (IDLE, PLAY, GAP), default widths, and `TICK_DIV` default constant.
- Sub-module `tone_gen`: inputs clk, rst, en, half_period; output dac_out. It is the programmable square-wave generator.
- Arbiter, prescaler, duration counter and FSM stay in `tone_arbiter`.

## Test plan
Benches use TICK_DIV = 10 and GAP_MS = 2.
- Single request, hp = 3, D = 4 → 40 cycles of 6-cycle period on `dac_out` starting T+2; `busy` high for 60 cycles total; `dac_out` = 0 during GAP.
- Requesters 1 and 2 valid together, `rr_ptr` = 0 → 1 served, then 2; then requester 1 reasserted with 2 → 2 wins only if `rr_ptr` = 2.
- D = 0 from requester 3 → `req_ready[3]` pulses once, `dac_out` stays 0, 20-cycle GAP, back to IDLE.
- hp = 0, D = 3 → `busy` high 50 cycles, `dac_out` constantly 0.
- Reset asserted mid-PLAY → `dac_out`, `busy` and `req_ready` go 0 asynchronously; after release the FSM is IDLE and `rr_ptr` = 0.
- `TONE_PREEMPT_EN`: requester 0 valid at cycle 15 of requester 2's PLAY → transfer that cycle, new tone from T+2, full D₀ duration, no gap inserted before it.
